// File: rtl/cdc_hs_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cdc_hs_rx_pkg : shared state encoding and defaults for the handshake receiver
// Revision 1.0
// ----------------------------------------------------------------------------
package cdc_hs_rx_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_WAIT_RDY = 2'b01;
  localparam logic [1:0] ST_WAIT_REL = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    WAIT_RDY = ST_WAIT_RDY,
    WAIT_REL = ST_WAIT_REL
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cdc_hs_rx_sync_ff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_ff : parameterized-depth single-bit level synchronizer
// Revision 1.0
// ----------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clkb,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clkb or negedge rst) begin
    if (!rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_hs_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cdc_hs_rx : clkb-side receiver of a four-phase req/ack word transfer
// Revision 1.0
// ----------------------------------------------------------------------------
module cdc_hs_rx
  import cdc_hs_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic              clkb,
  input  logic              rst,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] data_b,
  output logic              valid_b,
  input  logic              ready_b,
  output logic [CNT_W-1:0]  cnt_b,
  output logic              err_b
);

  logic              req_s;
  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clkb (clkb),
    .rst  (rst),
    .d    (req_a),
    .q    (req_s)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        // data_a has been stable for the whole synchronizer latency here
        if (req_s) begin
          data_d  = data_a;
          valid_d = 1'b1;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (!req_s) begin
          err_d = 1'b1;
        end
        if (valid_q && ready_b) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkb or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ack_b   = ack_q;
  assign valid_b = valid_q;
  assign data_b  = data_q;
  assign cnt_b   = cnt_q;
  assign err_b   = err_q;

endmodule
`default_nettype wire

// File: doc/cdc_hs_rx.md
# cdc_hs_rx

Receiving end of the four-phase req/ack handshake that carries a data word from clock domain a into the slow domain b. The block sits entirely in clkb. It synchronizes the incoming asynchronous `req_a` level, captures `data_a` once the request is safely seen, and presents the word on a local valid/ready port. It returns `ack_b` to the sender and releases it only after the request is withdrawn.

## Interface
Parameters:
- DATA_W, 8, width of transferred word
- SYNC_STAGES, 2, flops in req synchronizer; legal ≥ 2
- CNT_W, 8, width of accepted-transfer counter

Ports:
- clkb  input  1  single clock of the block
- rst  input  1  reset, asynchronous, active-low
- req_a  input  1  request level from domain a; asynchronous to clkb
- data_a  input  DATA_W  payload; sender holds it stable while req_a=1 and until ack_b seen low
- ack_b  output  1  acknowledge level back to domain a; registered
- data_b  output  DATA_W  captured word; registered
- valid_b  output  1  data_b valid to local consumer
- ready_b  input  1  local consumer accepts data_b
- cnt_b  output  CNT_W  number of accepted transfers, wraps
- err_b  output  1  sticky protocol-violation flag

## Operation
- req_a passes through a SYNC_STAGES-deep flop chain. req_s is the last stage. Only req_s is used internally.
- FSM states:
  - IDLE: ack_b=0, valid_b=0. If req_s=1, load data_a into data_b, set valid_b=1, go to WAIT_RDY.
  - WAIT_RDY: valid_b=1, data_b frozen. On valid_b&ready_b, clear valid_b, set ack_b=1, increment cnt_b, go to WAIT_REL.
  - WAIT_REL: ack_b=1. When req_s=0, clear ack_b and go to IDLE.
- data_a is sampled only in IDLE with req_s=1, so data has been stable ≥ SYNC_STAGES cycles. No data synchronizer is used.
- ready_b is ignored outside WAIT_RDY.
- cnt_b adds 1 modulo 2^CNT_W per accepted transfer. All-ones wraps to 0.
- err_b is set if req_s=0 while in WAIT_RDY (request withdrawn before ack):
  - The captured word is still delivered.
  - The FSM proceeds normally: in WAIT_REL with req_s already 0, ack_b is high for exactly one cycle.
  - err_b is cleared only by reset.
- No new request is captured while in WAIT_RDY or WAIT_REL. Back-to-back transfers need req_s to return to 0 first.

## Timing
- Reset values: ack_b=0, valid_b=0, data_b=0, cnt_b=0, err_b=0, sync chain=0, FSM=IDLE.
- Let req_a rise before clkb edge 0. req_s=1 after edge SYNC_STAGES−1. valid_b=1 and data_b are updated at edge SYNC_STAGES (2 cycles for default).
- valid_b&ready_b at edge n: valid_b=0, ack_b=1, cnt_b updated, all at edge n.
- If ready_b is already high when valid_b rises, the transfer is accepted at the next edge. valid_b is high for minimum 1 cycle.
- req_a falls before edge m: ack_b=0 at edge m+SYNC_STAGES. FSM is in IDLE and accepts a new req_s=1 one edge later.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). If req_a is still high after reset release, the word is captured again as a new transfer. This is a documented duplicate; the sender owns its recovery.

## Structure
- Shared package holds:
  - FSM state localparams: IDLE=2'b00, WAIT_RDY=2'b01, WAIT_REL=2'b10. Unused 2'b11 returns to IDLE.
  - Default SYNC_STAGES.
- One sub-module: sync_ff, a parameterized-depth single-bit synchronizer (clkb, rst, d, q). It is reused by the matching domain-a sender for ack_b.
- Top holds the FSM, data register, counter and error flag.

## Test plan
- Single transfer: data_a=8'hA5, req_a↑, ready_b=1 constant → valid_b high 1 cycle with data_b=8'hA5 at edge 2. ack_b↑ next edge, cnt_b=1. req_a↓ → ack_b↓ 2 edges later.
- Backpressure: ready_b=0 for 10 cycles after valid_b rises → valid_b and data_b held and ack_b=0 throughout. ready_b=1 → ack_b↑ in the same cycle valid_b↓.
- Protocol violation: req_a↓ while in WAIT_RDY → err_b=1 and stays 1. Word delivered on ready_b. ack_b is a one-cycle pulse.
- Counter wrap: 256 complete handshakes with CNT_W=8 → cnt_b returns to 0. No extra valid_b pulses.
- Reset mid-operation: assert rst in WAIT_REL → all outputs 0 asynchronously. Release with req_a=1 → new capture 2 edges later.
- Data change ignored: data_a changes from 8'h11 to 8'h22 while in WAIT_REL → data_b stays 8'h11.
